control_pipe: RTL and testbench

- Consumer end of the decode-stage control bundle.
- Registers the decoder's EX/MEM/WB control signals through the ID/EX, EX/MEM and MEM/WB boundaries.
- Resolves the write-back destination register.
- Detects load-use hazards and generates stall and bubble.
- Produces forwarding selects for the EX-stage ALU operand muxes.
- Sits between the control decoder and the datapath stage registers of the 5-stage MIPS pipeline.

---
 rtl/ctrl_pkg.sv | 70 +++++++
 rtl/control_fwd_unit.sv | 51 +++++
 rtl/control_pipe.sv | 112 +++++++++++
 tb/tb_control_pipe.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the decode-stage control pipeline.
//   - ex_ctrl_t / mem_ctrl_t / wb_ctrl_t: decoder control groups by consuming stage
//   - id_ex_t / ex_mem_t / mem_wb_t: contents of each pipeline boundary register
//   - *_BUBBLE: all-zero contents used to insert a bubble
//   - FWD_*: encodings of the EX operand forwarding selects
package ctrl_pkg;

  localparam int CTRL_REG_W   = 5;
  localparam int CTRL_ALUOP_W = 2;
  localparam int CTRL_OTHER_W = 4;

  typedef logic [CTRL_REG_W-1:0] reg_idx_t;

  typedef struct packed {
    logic                    regdst;
    logic                    alusrc;
    logic [CTRL_ALUOP_W-1:0] aluop;
    logic [CTRL_OTHER_W-1:0] other;
  } ex_ctrl_t;

  typedef struct packed {
    logic memread;
    logic memwrite;
    logic branch;
  } mem_ctrl_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } wb_ctrl_t;

  localparam ex_ctrl_t  EX_BUBBLE  = '0;
  localparam mem_ctrl_t MEM_BUBBLE = '0;
  localparam wb_ctrl_t  WB_BUBBLE  = '0;

  typedef struct packed {
    ex_ctrl_t  ex;
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
    reg_idx_t  rs;
    reg_idx_t  rt;
    reg_idx_t  rd;
  } id_ex_t;

  typedef struct packed {
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
    reg_idx_t  dst;
  } ex_mem_t;

  typedef struct packed {
    wb_ctrl_t wb;
    reg_idx_t dst;
  } mem_wb_t;

  // Bubbles also zero the register fields so they can never match anything.
  localparam id_ex_t  ID_EX_BUBBLE  = '0;
  localparam ex_mem_t EX_MEM_BUBBLE = '0;
  localparam mem_wb_t MEM_WB_BUBBLE = '0;

  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  // Write-back destination: rd for R-type (regdst=1), rt otherwise.
  function automatic reg_idx_t resolve_dst(input id_ex_t s);
    return s.ex.regdst ? s.rd : s.rt;
  endfunction

endpackage

// File: rtl/control_fwd_unit.sv
// control_fwd_unit: combinational load-use hazard detection and EX operand
// forwarding selection.
//   id_rs, id_rt             register fields of the instruction currently in ID
//   flush                    branch-taken kill; suppresses the stall
//   idex_memread/rs/rt       instruction in ID/EX
//   exmem_regwrite/dst       producer one stage ahead (newest)
//   memwb_regwrite/dst       producer two stages ahead (older)
//   stall                    hold PC and IF/ID, bubble into ID/EX
//   fwd_a, fwd_b             forward selects for ID/EX rs / rt
module control_fwd_unit
  import ctrl_pkg::*;
#(
  parameter int REG_W = CTRL_REG_W
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             flush,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rs,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             exmem_regwrite,
  input  logic [REG_W-1:0] exmem_dst,
  input  logic             memwb_regwrite,
  input  logic [REG_W-1:0] memwb_dst,
  output logic             stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

  // Newest producer wins; register 0 is hardwired and never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] src,
    input logic             em_wr,
    input logic [REG_W-1:0] em_dst,
    input logic             mw_wr,
    input logic [REG_W-1:0] mw_dst
  );
    if (em_wr && (em_dst != '0) && (em_dst == src)) return FWD_EXMEM;
    if (mw_wr && (mw_dst != '0) && (mw_dst == src)) return FWD_MEMWB;
    return FWD_NONE;
  endfunction

  // A load whose result is needed by the very next instruction cannot be
  // forwarded in time; a flush kills both instructions, so no stall then.
  assign stall = idex_memread && (idex_rt != '0) &&
                 ((idex_rt == id_rs) || (idex_rt == id_rt)) && !flush;

  assign fwd_a = fwd_sel(idex_rs, exmem_regwrite, exmem_dst, memwb_regwrite, memwb_dst);
  assign fwd_b = fwd_sel(idex_rt, exmem_regwrite, exmem_dst, memwb_regwrite, memwb_dst);

endmodule

// File: rtl/control_pipe.sv
// control_pipe: carries decoder control bundles through ID/EX, EX/MEM and
// MEM/WB, resolves the write-back destination, and produces stall and
// forwarding selects for the EX stage.
//   i_clk, i_rst             clock (rising edge), async active-high reset
//   i_regdst..i_memtoreg     decoder controls for the instruction in ID
//   i_rs, i_rt, i_rd         register fields of the instruction in ID
//   i_flush                  branch taken: kill ID/EX and EX/MEM contents
//   o_ex_*                   EX-stage controls (from ID/EX)
//   o_mem_*                  MEM-stage controls (from EX/MEM)
//   o_wb_*, o_wb_dst         WB-stage controls and destination (from MEM/WB)
//   o_stall                  load-use hazard hold request
//   o_fwd_a, o_fwd_b         EX operand forward selects
module control_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_W   = CTRL_REG_W,
  parameter int ALUOP_W = CTRL_ALUOP_W,
  parameter int OTHER_W = CTRL_OTHER_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_regdst,
  input  logic               i_alusrc,
  input  logic [ALUOP_W-1:0] i_aluop,
  input  logic [OTHER_W-1:0] i_other,
  input  logic               i_memread,
  input  logic               i_memwrite,
  input  logic               i_branch,
  input  logic               i_regwrite,
  input  logic               i_memtoreg,
  input  logic [REG_W-1:0]   i_rs,
  input  logic [REG_W-1:0]   i_rt,
  input  logic [REG_W-1:0]   i_rd,
  input  logic               i_flush,
  output logic               o_ex_alusrc,
  output logic [ALUOP_W-1:0] o_ex_aluop,
  output logic [OTHER_W-1:0] o_ex_other,
  output logic               o_mem_memread,
  output logic               o_mem_memwrite,
  output logic               o_mem_branch,
  output logic               o_wb_regwrite,
  output logic               o_wb_memtoreg,
  output logic [REG_W-1:0]   o_wb_dst,
  output logic               o_stall,
  output logic [1:0]         o_fwd_a,
  output logic [1:0]         o_fwd_b
);

  id_ex_t  id_ex;
  ex_mem_t ex_mem;
  mem_wb_t mem_wb;
  id_ex_t  id_next;
  logic    stall;

  assign id_next = '{
    ex:  '{regdst: i_regdst, alusrc: i_alusrc, aluop: i_aluop, other: i_other},
    mem: '{memread: i_memread, memwrite: i_memwrite, branch: i_branch},
    wb:  '{regwrite: i_regwrite, memtoreg: i_memtoreg},
    rs:  i_rs,
    rt:  i_rt,
    rd:  i_rd
  };

  control_fwd_unit #(.REG_W(REG_W)) u_fwd (
    .id_rs          (i_rs),
    .id_rt          (i_rt),
    .flush          (i_flush),
    .idex_memread   (id_ex.mem.memread),
    .idex_rs        (id_ex.rs),
    .idex_rt        (id_ex.rt),
    .exmem_regwrite (ex_mem.wb.regwrite),
    .exmem_dst      (ex_mem.dst),
    .memwb_regwrite (mem_wb.wb.regwrite),
    .memwb_dst      (mem_wb.dst),
    .stall          (stall),
    .fwd_a          (o_fwd_a),
    .fwd_b          (o_fwd_b)
  );

  // NOTE: every stage register is cleared on reset so no stale control bit
  // can write memory or the register file; non-blocking assignments let each
  // boundary sample the previous stage's old value on the same edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      id_ex  <= ID_EX_BUBBLE;
      ex_mem <= EX_MEM_BUBBLE;
      mem_wb <= MEM_WB_BUBBLE;
    end else begin
      mem_wb <= '{wb: ex_mem.wb, dst: ex_mem.dst};
      if (i_flush) begin
        ex_mem <= EX_MEM_BUBBLE;
        id_ex  <= ID_EX_BUBBLE;
      end else begin
        ex_mem <= '{mem: id_ex.mem, wb: id_ex.wb, dst: resolve_dst(id_ex)};
        // On a stall the ID instruction is held upstream and re-presented.
        id_ex  <= stall ? ID_EX_BUBBLE : id_next;
      end
    end
  end

  assign o_ex_alusrc    = id_ex.ex.alusrc;
  assign o_ex_aluop     = id_ex.ex.aluop;
  assign o_ex_other     = id_ex.ex.other;
  assign o_mem_memread  = ex_mem.mem.memread;
  assign o_mem_memwrite = ex_mem.mem.memwrite;
  assign o_mem_branch   = ex_mem.mem.branch;
  assign o_wb_regwrite  = mem_wb.wb.regwrite;
  assign o_wb_memtoreg  = mem_wb.wb.memtoreg;
  assign o_wb_dst       = mem_wb.dst;
  assign o_stall        = stall;

endmodule

// File: tb/tb_control_pipe.sv
// Bench for control_pipe: a directed table of instruction bundles with
// hand-derived expected outputs, a mid-stream asynchronous reset sequence,
// and a randomized run compared against an instruction-level pipeline model.
module tb_control_pipe;

  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic [1:0] aluop;
    logic [3:0] other;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       regwrite;
    logic       memtoreg;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } instr_t;

  typedef enum {K_NOP, K_R, K_ADDI, K_LW, K_SW} kind_e;

  typedef struct packed {
    instr_t     in;
    logic       flush;
    logic [1:0] ex_aluop;
    logic [2:0] mem;
    logic       wb_rw;
    logic [4:0] wb_dst;
    logic       stall;
    logic [1:0] fa;
    logic [1:0] fb;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       regdst, alusrc, memread, memwrite, branch, regwrite, memtoreg, flush;
  logic [1:0] aluop;
  logic [3:0] other;
  logic [4:0] rs, rt, rd;
  logic       ex_alusrc, mem_memread, mem_memwrite, mem_branch;
  logic       wb_regwrite, wb_memtoreg, stall;
  logic [1:0] ex_aluop, fwd_a, fwd_b;
  logic [3:0] ex_other;
  logic [4:0] wb_dst;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  control_pipe dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_regdst       (regdst),
    .i_alusrc       (alusrc),
    .i_aluop        (aluop),
    .i_other        (other),
    .i_memread      (memread),
    .i_memwrite     (memwrite),
    .i_branch       (branch),
    .i_regwrite     (regwrite),
    .i_memtoreg     (memtoreg),
    .i_rs           (rs),
    .i_rt           (rt),
    .i_rd           (rd),
    .i_flush        (flush),
    .o_ex_alusrc    (ex_alusrc),
    .o_ex_aluop     (ex_aluop),
    .o_ex_other     (ex_other),
    .o_mem_memread  (mem_memread),
    .o_mem_memwrite (mem_memwrite),
    .o_mem_branch   (mem_branch),
    .o_wb_regwrite  (wb_regwrite),
    .o_wb_memtoreg  (wb_memtoreg),
    .o_wb_dst       (wb_dst),
    .o_stall        (stall),
    .o_fwd_a        (fwd_a),
    .o_fwd_b        (fwd_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic instr_t mk(input kind_e k, input int s, input int t, input int d);
    instr_t x = '0;
    case (k)
      K_R:    begin x.regdst = 1'b1; x.regwrite = 1'b1; x.aluop = 2'b10; x.other = 4'h2; end
      K_ADDI: begin x.alusrc = 1'b1; x.regwrite = 1'b1; x.aluop = 2'b11; end
      K_LW:   begin x.alusrc = 1'b1; x.memread = 1'b1; x.regwrite = 1'b1; x.memtoreg = 1'b1; end
      K_SW:   begin x.alusrc = 1'b1; x.memwrite = 1'b1; x.memtoreg = 1'b1; end
      default: ;
    endcase
    x.rs = 5'(s);
    x.rt = 5'(t);
    x.rd = 5'(d);
    return x;
  endfunction

  function automatic vec_t v(input instr_t in, input logic f, input logic [1:0] exa,
                             input logic [2:0] m, input logic wrw, input int wd,
                             input logic st, input logic [1:0] a, input logic [1:0] b);
    vec_t r;
    r.in = in; r.flush = f; r.ex_aluop = exa; r.mem = m; r.wb_rw = wrw;
    r.wb_dst = 5'(wd); r.stall = st; r.fa = a; r.fb = b;
    return r;
  endfunction

  task automatic drive(input instr_t x, input logic f);
    regdst = x.regdst; alusrc = x.alusrc; aluop = x.aluop; other = x.other;
    memread = x.memread; memwrite = x.memwrite; branch = x.branch;
    regwrite = x.regwrite; memtoreg = x.memtoreg;
    rs = x.rs; rt = x.rt; rd = x.rd; flush = f;
  endtask

  function automatic logic [21:0] all_outs();
    return {ex_alusrc, ex_aluop, ex_other, mem_memread, mem_memwrite, mem_branch,
            wb_regwrite, wb_memtoreg, wb_dst, stall, fwd_a, fwd_b};
  endfunction

  // ---------------- reference model (instruction-level) ----------------
  // age[0] is the instruction in EX, age[1] in MEM, age[2] in WB.
  instr_t age [3];

  function automatic logic [4:0] dest_of(input instr_t x);
    return x.regdst ? x.rd : x.rt;
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] src);
    for (int k = 1; k <= 2; k++)
      if (age[k].regwrite && dest_of(age[k]) != 0 && dest_of(age[k]) == src)
        return (k == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  function automatic logic model_stall(input instr_t in, input logic f);
    return age[0].memread && age[0].rt != 0 && (age[0].rt == in.rs || age[0].rt == in.rt) && !f;
  endfunction

  vec_t vecs [21];

  initial begin
    instr_t nop, cur;
    logic   cur_f, exp_st;
    logic   held;

    nop = mk(K_NOP, 0, 0, 0);
    drive(nop, 1'b0);

    // Directed table: inputs for the row, expected outputs seen before its edge.
    vecs[0]  = v(mk(K_R, 1, 6, 5),    0, 2'b00, 3'b000, 0, 0,  0, 2'b00, 2'b00);
    vecs[1]  = v(mk(K_ADDI, 2, 6, 7), 0, 2'b10, 3'b000, 0, 0,  0, 2'b00, 2'b00);
    vecs[2]  = v(nop,                 0, 2'b11, 3'b000, 0, 0,  0, 2'b00, 2'b00);
    vecs[3]  = v(nop,                 0, 2'b00, 3'b000, 1, 5,  0, 2'b00, 2'b00);
    vecs[4]  = v(mk(K_LW, 0, 8, 0),   0, 2'b00, 3'b000, 1, 6,  0, 2'b00, 2'b00);
    vecs[5]  = v(mk(K_R, 8, 1, 10),   0, 2'b00, 3'b000, 0, 0,  1, 2'b00, 2'b00);
    vecs[6]  = v(mk(K_R, 8, 1, 10),   0, 2'b00, 3'b100, 0, 0,  0, 2'b00, 2'b00);
    vecs[7]  = v(nop,                 0, 2'b10, 3'b000, 1, 8,  0, 2'b01, 2'b00);
    vecs[8]  = v(mk(K_ADDI, 0, 3, 0), 0, 2'b00, 3'b000, 0, 0,  0, 2'b00, 2'b00);
    vecs[9]  = v(mk(K_ADDI, 0, 3, 0), 0, 2'b11, 3'b000, 1, 10, 0, 2'b00, 2'b00);
    vecs[10] = v(mk(K_R, 3, 3, 11),   0, 2'b11, 3'b000, 0, 0,  0, 2'b00, 2'b10);
    vecs[11] = v(nop,                 0, 2'b10, 3'b000, 1, 3,  0, 2'b10, 2'b10);
    vecs[12] = v(mk(K_ADDI, 0, 0, 0), 0, 2'b00, 3'b000, 1, 3,  0, 2'b00, 2'b00);
    vecs[13] = v(mk(K_R, 0, 0, 12),   0, 2'b11, 3'b000, 1, 11, 0, 2'b00, 2'b00);
    vecs[14] = v(mk(K_ADDI, 0, 14, 0),0, 2'b10, 3'b000, 0, 0,  0, 2'b00, 2'b00);
    vecs[15] = v(mk(K_LW, 0, 4, 0),   0, 2'b11, 3'b000, 1, 0,  0, 2'b00, 2'b00);
    vecs[16] = v(mk(K_R, 4, 0, 13),   1, 2'b00, 3'b000, 1, 12, 0, 2'b00, 2'b00);
    vecs[17] = v(mk(K_SW, 0, 9, 0),   0, 2'b00, 3'b000, 1, 14, 0, 2'b00, 2'b00);
    vecs[18] = v(mk(K_R, 9, 0, 1),    0, 2'b00, 3'b000, 0, 0,  0, 2'b00, 2'b00);
    vecs[19] = v(nop,                 0, 2'b10, 3'b010, 0, 0,  0, 2'b00, 2'b00);
    vecs[20] = v(nop,                 0, 2'b00, 3'b000, 0, 9,  0, 2'b00, 2'b00);

    // Reset held across edges: everything zero.
    @(posedge clk); @(posedge clk); #1;
    check("reset_outputs", 32'(all_outs()), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].in, vecs[i].flush);
      @(negedge clk);
      check($sformatf("row%0d_ex_aluop", i), 32'(ex_aluop), 32'(vecs[i].ex_aluop));
      check($sformatf("row%0d_mem", i), 32'({mem_memread, mem_memwrite, mem_branch}), 32'(vecs[i].mem));
      check($sformatf("row%0d_wb", i), 32'({wb_regwrite, wb_dst}), 32'({vecs[i].wb_rw, vecs[i].wb_dst}));
      check($sformatf("row%0d_stall", i), 32'(stall), 32'(vecs[i].stall));
      check($sformatf("row%0d_fwd", i), 32'({fwd_a, fwd_b}), 32'({vecs[i].fa, vecs[i].fb}));
      @(posedge clk); #1;
    end

    // Mid-stream asynchronous reset between edges.
    drive(mk(K_ADDI, 0, 5, 0), 1'b0);
    @(posedge clk); #1;
    check("pre_reset_ex_aluop", 32'(ex_aluop), 32'(2'b11));
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", 32'(all_outs()), 32'd0);
    @(posedge clk); #1;
    check("reset_held_outputs", 32'(all_outs()), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_release_no_edge", 32'({ex_alusrc, ex_aluop}), 32'd0);
    @(posedge clk); #1;
    check("post_release_first_ex", 32'({ex_alusrc, ex_aluop, wb_regwrite}), 32'({1'b1, 2'b11, 1'b0}));

    // Randomized run against the instruction-level model.
    rst = 1'b1;
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) age[k] = '0;
    held = 1'b0;
    cur  = nop;
    for (int n = 0; n < 1500; n++) begin
      if (!held) begin
        cur = instr_t'({$urandom, $urandom});
        cur.memread = ($urandom_range(0, 2) == 0);
        cur.rs = 5'($urandom_range(0, 3));
        cur.rt = 5'($urandom_range(0, 3));
        cur.rd = 5'($urandom_range(0, 3));
      end
      cur_f = ($urandom_range(0, 7) == 0);
      drive(cur, cur_f);
      exp_st = model_stall(cur, cur_f);
      @(negedge clk);
      check($sformatf("rnd%0d_ex", n), 32'({ex_alusrc, ex_aluop, ex_other}),
            32'({age[0].alusrc, age[0].aluop, age[0].other}));
      check($sformatf("rnd%0d_mem", n), 32'({mem_memread, mem_memwrite, mem_branch}),
            32'({age[1].memread, age[1].memwrite, age[1].branch}));
      check($sformatf("rnd%0d_wb", n), 32'({wb_regwrite, wb_memtoreg, wb_dst}),
            32'({age[2].regwrite, age[2].memtoreg, dest_of(age[2])}));
      check($sformatf("rnd%0d_stall", n), 32'(stall), 32'(exp_st));
      check($sformatf("rnd%0d_fwd", n), 32'({fwd_a, fwd_b}),
            32'({model_fwd(age[0].rs), model_fwd(age[0].rt)}));
      @(posedge clk);
      age[2] = age[1];
      age[1] = cur_f ? instr_t'('0) : age[0];
      age[0] = (cur_f || exp_st) ? instr_t'('0) : cur;
      held = exp_st;
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
